// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and branch/jump squash.
// Also counts inserted load-use bubbles in a saturating counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              regdst,
    input  logic              jump,
    input  logic              branch,
    input  logic              memRead,
    input  logic              memToReg,
    input  logic              memWrite,
    input  logic              aluSrc,
    input  logic              regWrite,
    input  logic [1:0]        aluOp,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic              ex_memRead,
    output logic              ex_memToReg,
    output logic              ex_memWrite,
    output logic              ex_aluSrc,
    output logic              ex_regWrite,
    output logic [1:0]        ex_aluOp,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_wreg,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int CTRL_W      = 10;
    localparam int CTRL_MEMRD  = 6;

    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [REG_W-1:0]  wreg_d, wreg_q;
    logic [REG_W-1:0]  rs_d, rs_q, rt_d, rt_q;
    logic [DATA_W-1:0] pc4_d, pc4_q;
    logic [DATA_W-1:0] rs_data_d, rs_data_q;
    logic [DATA_W-1:0] rt_data_d, rt_data_q;
    logic [DATA_W-1:0] imm_d, imm_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              uses_rs, uses_rt, hazard, slot_live;

    assign ctrl_in = {regdst, jump, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOp};

    // Hazard: a live load in EX writes a nonzero register that the ID instruction reads.
    always_comb begin
        uses_rs = !jump;
        uses_rt = !aluSrc | memWrite | branch;
        hazard  = id_valid & valid_q & ctrl_q[CTRL_MEMRD] & (wreg_q != '0)
                & ((uses_rs & (wreg_q == id_rs)) | (uses_rt & (wreg_q == id_rt)));
        stall   = hold | (hazard & !flush);
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        wreg_d    = wreg_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        pc4_d     = pc4_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;
        slot_live = 1'b0;
        if (!hold) begin
            // Squashed, bubbled and empty slots all carry zeroed control so EX can't commit anything.
            slot_live = id_valid & !flush & !hazard;
            valid_d   = slot_live;
            ctrl_d    = slot_live ? ctrl_in : '0;
            wreg_d    = slot_live ? (regdst ? id_rd : id_rt) : '0;
            rs_d      = id_rs;
            rt_d      = id_rt;
            pc4_d     = id_pc4;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            if (hazard && !flush && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            wreg_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            wreg_q    <= wreg_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign {ex_regdst, ex_jump, ex_branch, ex_memRead, ex_memToReg,
            ex_memWrite, ex_aluSrc, ex_regWrite, ex_aluOp} = ctrl_q;
    assign ex_valid   = valid_q;
    assign ex_wreg    = wreg_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with a 2-bit bubble counter exercises saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush, hold;
    logic [9:0]  in_ctrl;
    logic        regdst, jump, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
    logic [1:0]  aluOp;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    assign {regdst, jump, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOp} = in_ctrl;

    logic        stall, ex_valid, ex_regdst, ex_jump, ex_branch, ex_memRead, ex_memToReg;
    logic        ex_memWrite, ex_aluSrc, ex_regWrite;
    logic [1:0]  ex_aluOp;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg;
    logic [15:0] bubble_cnt;

    logic        s_stall, s_valid, s_regdst, s_jump, s_branch, s_memRead, s_memToReg;
    logic        s_memWrite, s_aluSrc, s_regWrite;
    logic [1:0]  s_aluOp;
    logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
    logic [4:0]  s_rs, s_rt, s_wreg;
    logic [1:0]  s_bubble_cnt;

    wire [9:0] ex_ctrl = {ex_regdst, ex_jump, ex_branch, ex_memRead, ex_memToReg,
                          ex_memWrite, ex_aluSrc, ex_regWrite, ex_aluOp};

    id_ex_stage u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .regdst(regdst), .jump(jump), .branch(branch), .memRead(memRead),
        .memToReg(memToReg), .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
        .aluOp(aluOp), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
        .ex_regdst(ex_regdst), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite),
        .ex_aluSrc(ex_aluSrc), .ex_regWrite(ex_regWrite), .ex_aluOp(ex_aluOp),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .regdst(regdst), .jump(jump), .branch(branch), .memRead(memRead),
        .memToReg(memToReg), .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
        .aluOp(aluOp), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold(hold), .stall(s_stall), .ex_valid(s_valid),
        .ex_regdst(s_regdst), .ex_jump(s_jump), .ex_branch(s_branch),
        .ex_memRead(s_memRead), .ex_memToReg(s_memToReg), .ex_memWrite(s_memWrite),
        .ex_aluSrc(s_aluSrc), .ex_regWrite(s_regWrite), .ex_aluOp(s_aluOp),
        .ex_pc4(s_pc4), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_wreg(s_wreg), .bubble_cnt(s_bubble_cnt)
    );

    always #5 clk = ~clk;

    // Instruction templates: {regdst,jump,branch,memRead,memToReg,memWrite,aluSrc,regWrite,aluOp}
    localparam logic [9:0] C_RTYPE = 10'b1000000110;
    localparam logic [9:0] C_LW    = 10'b0001101100;
    localparam logic [9:0] C_ADDI  = 10'b0000001100;

    int checks = 0;
    int errors = 0;

    // Reference model of what the EX slot should hold
    bit          m_valid;
    logic [9:0]  m_ctrl;
    logic [4:0]  m_wreg, m_rs, m_rt;
    logic [31:0] m_pc4, m_rs_data, m_rt_data, m_imm;
    int          m_cnt, m_cnt2;

    function automatic bit model_hazard();
        bit reads_rs, reads_rt, ex_is_load;
        reads_rs   = (jump == 1'b0);
        reads_rt   = (aluSrc == 1'b0) || memWrite || branch;
        ex_is_load = m_valid && m_ctrl[6] && (m_wreg != 5'd0);
        return id_valid && ex_is_load &&
               ((reads_rs && m_wreg == id_rs) || (reads_rt && m_wreg == id_rt));
    endfunction

    function automatic bit model_stall();
        return hold || (model_hazard() && !flush);
    endfunction

    task automatic model_edge();
        bit haz, live;
        if (rst) begin
            m_valid = 0; m_ctrl = '0; m_wreg = '0; m_rs = '0; m_rt = '0;
            m_pc4 = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (!hold) begin
            haz  = model_hazard();
            live = id_valid && !flush && !haz;
            m_valid   = live;
            m_ctrl    = live ? in_ctrl : 10'd0;
            m_wreg    = live ? (regdst ? id_rd : id_rt) : 5'd0;
            m_rs      = id_rs;
            m_rt      = id_rt;
            m_pc4     = id_pc4;
            m_rs_data = id_rs_data;
            m_rt_data = id_rt_data;
            m_imm     = id_imm;
            if (haz && !flush) begin
                if (m_cnt  < 65535) m_cnt  = m_cnt + 1;
                if (m_cnt2 < 3)     m_cnt2 = m_cnt2 + 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        id_valid = 1'b1; in_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    task automatic drive_idle();
        rst = 0; hold = 0; flush = 0; id_valid = 0; in_ctrl = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        set_instr(10'h3ff, 5'd7, 5'd7, 5'd7);
        hold = 1; flush = 1; rst = 1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
        checks++; if (ex_ctrl !== 10'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ex_ctrl); end
        checks++; if ({ex_wreg, ex_rs, ex_rt} !== 15'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {ex_wreg, ex_rs, ex_rt}); end
        checks++; if ({ex_pc4, ex_rs_data, ex_rt_data, ex_imm} !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}); end
        checks++; if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0", bubble_cnt, s_bubble_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hold got %0b want 1", stall); end
        hold = 0; flush = 0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
        rst = 0;
    endtask

    task automatic test_pass_through();
        drive_idle();
        set_instr(C_RTYPE, 5'd2, 5'd3, 5'd4);
        id_rs_data = 32'h11; id_rt_data = 32'h22; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %0b want 0", stall); end
        tick();
        checks++; if (ex_wreg !== 5'd4) begin errors++; $display("FAIL pass_wreg got %0d want 4", ex_wreg); end
        checks++; if (ex_aluOp !== 2'b10) begin errors++; $display("FAIL pass_aluop got %b want 10", ex_aluOp); end
        checks++; if (ex_rs_data !== 32'h11 || ex_rt_data !== 32'h22) begin errors++; $display("FAIL pass_data got %h/%h want 11/22", ex_rs_data, ex_rt_data); end
        checks++; if (ex_valid !== 1'b1 || ex_regWrite !== 1'b1) begin errors++; $display("FAIL pass_valid got %0b/%0b want 1/1", ex_valid, ex_regWrite); end
    endtask

    task automatic test_load_use();
        drive_idle();
        set_instr(C_LW, 5'd1, 5'd5, 5'd9);
        tick();
        set_instr(C_RTYPE, 5'd5, 5'd6, 5'd7); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0 || ex_wreg !== 5'd0) begin errors++; $display("FAIL lu_bubble got v=%0b c=%h w=%0d want 0", ex_valid, ex_ctrl, ex_wreg); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bubble_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %0b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd7) begin errors++; $display("FAIL lu_dep_enters got v=%0b w=%0d want 1/7", ex_valid, ex_wreg); end
        set_instr(C_LW, 5'd1, 5'd0, 5'd9);
        tick();
        set_instr(C_RTYPE, 5'd0, 5'd0, 5'd7); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_reg0 got %0b want 0", stall); end
        set_instr(C_LW, 5'd1, 5'd5, 5'd9);
        tick();
        set_instr(C_ADDI, 5'd3, 5'd5, 5'd0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_addi got %0b want 0", stall); end
        tick();
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_final got %0d want 1", bubble_cnt); end
    endtask

    task automatic test_flush_priority();
        drive_idle();
        set_instr(C_LW, 5'd1, 5'd5, 5'd9);
        tick();
        set_instr(C_RTYPE, 5'd5, 5'd6, 5'd7); flush = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0) begin errors++; $display("FAIL flush_slot got v=%0b c=%h want 0", ex_valid, ex_ctrl); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", bubble_cnt); end
    endtask

    task automatic test_hold();
        logic [31:0] pc_saved;
        drive_idle();
        set_instr(C_RTYPE, 5'd1, 5'd2, 5'd3);
        pc_saved = id_pc4;
        tick();
        hold = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(in_ctrl ^ 10'h155, 5'($urandom), 5'($urandom), 5'($urandom)); #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got %0b want 1", i, stall); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd3 || ex_ctrl !== C_RTYPE || ex_pc4 !== pc_saved)
                begin errors++; $display("FAIL hold_frozen[%0d] got v=%0b w=%0d c=%h pc=%h want 1/3/%h/%h", i, ex_valid, ex_wreg, ex_ctrl, ex_pc4, C_RTYPE, pc_saved); end
        end
        hold = 0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_release_stall got %0b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0) begin errors++; $display("FAIL hold_release_flush got v=%0b c=%h want 0", ex_valid, ex_ctrl); end
    endtask

    task automatic test_saturation();
        int exp_sat [5] = '{1, 2, 3, 3, 3};
        drive_idle();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            set_instr(C_LW, 5'd1, 5'd5, 5'd9);
            tick();
            set_instr(C_RTYPE, 5'd2, 5'd5, 5'd7);
            tick();
            checks++; if (s_bubble_cnt !== 2'(exp_sat[i]) || bubble_cnt !== 16'(i + 1))
                begin errors++; $display("FAIL sat_cnt[%0d] got %0d/%0d want %0d/%0d", i, s_bubble_cnt, bubble_cnt, exp_sat[i], i + 1); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [169:0] got, want;
        int bad = 0;
        drive_idle();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            hold     = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            in_ctrl  = 10'($urandom);
            if ($urandom_range(0, 2) == 0) in_ctrl = C_LW;
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
            id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            #1;
            checks++; if (stall !== model_stall() || s_stall !== model_stall())
                begin errors++; bad++; $display("FAIL rand_stall[%0d] got %0b/%0b want %0b", i, stall, s_stall, model_stall()); end
            tick();
            got  = {ex_valid, ex_ctrl, ex_wreg, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, bubble_cnt};
            want = {m_valid, m_ctrl, m_wreg, m_pc4, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, 16'(m_cnt)};
            checks++; if (got !== want || s_bubble_cnt !== 2'(m_cnt2))
                begin errors++; bad++; $display("FAIL rand_state[%0d] got %h/%0d want %h/%0d", i, got, s_bubble_cnt, want, m_cnt2); end
            if (bad > 10) break;
        end
    endtask

    initial begin
        drive_idle();
        @(posedge clk); #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_flush_priority();
        test_hold();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
